cond_logic_unit: RTL

//  Consumer end of the control bundle from the instruction decoder.
//  - Holds the architectural NZCV flag register.
//  - Evaluates the ARM condition field against the registered flags.
//  - Gates PCS/RegWrite/MemWrite into the write-enables the datapath uses.
//  - Counts executed and squashed instructions for debug/performance readout.
//  - Sits between the decoder and the register file, data memory and PC mux.

---
 rtl/cond_logic_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/cond_logic_unit.sv
// Condition-check stage: holds NZCV, evaluates the ARM condition field against the
// registered flags, gates decoder write requests, and counts executed/squashed instructions.
module cond_logic_unit #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegWrite,
    input  logic             MemWrite,
    output logic             PCSrc,
    output logic             RegWriteG,
    output logic             MemWriteG,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic n_f, z_f, c_f, v_f;
    logic cond_pass;
    logic issue;

    assign {n_f, z_f, c_f, v_f} = Flags;

    // Condition decode on the registered flags only; 1111 is treated as never.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = ~z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = ~c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = ~n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = ~v_f;
            4'b1000: cond_pass = c_f & ~z_f;
            4'b1001: cond_pass = ~c_f | z_f;
            4'b1010: cond_pass = ~(n_f ^ v_f);
            4'b1011: cond_pass = n_f ^ v_f;
            4'b1100: cond_pass = ~z_f & ~(n_f ^ v_f);
            4'b1101: cond_pass = z_f | (n_f ^ v_f);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Reset masks the enables so nothing is written while the block is held in reset.
    assign issue     = InstrValid & cond_pass & ~reset;
    assign CondEx    = cond_pass & ~reset;
    assign PCSrc     = PCS & issue;
    assign RegWriteG = RegWrite & issue;
    assign MemWriteG = MemWrite & issue;

    // NZ and CV halves update independently; gating on InstrValid first keeps X on FlagW out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Flags <= FLAGS_RST;
        end else if (InstrValid && cond_pass) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Saturating exec/squash counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ExecCount   <= '0;
            SquashCount <= '0;
        end else if (InstrValid) begin
            if (cond_pass) begin
                if (ExecCount != CNT_MAX) ExecCount <= ExecCount + CNT_W'(1);
            end else begin
                if (SquashCount != CNT_MAX) SquashCount <= SquashCount + CNT_W'(1);
            end
        end
    end

endmodule
